// File: rtl/fsm_input_debouncer_pkg.sv
// rtl/fsm_input_debouncer_pkg.sv - shared types and constants for the input debouncer
package fsm_input_debouncer_pkg;

  typedef enum logic {STABLE, PENDING} deb_state_t;

  localparam logic [7:0] GLITCH_MAX = 8'd255;

  // Increment that sticks at GLITCH_MAX instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == GLITCH_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchronizer for an asynchronous bus
module sync_chain #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stages [DEPTH];

  // Shift the raw value down the chain; every stage clears on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/fsm_input_debouncer.sv
// rtl/fsm_input_debouncer.sv - synchronize and symbol-debounce a 2-bit raw input
module fsm_input_debouncer
  import fsm_input_debouncer_pkg::*;
#(
  parameter int NSYNC           = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] raw_in,
  output logic [1:0] in_,
  output logic       change,
  output logic [7:0] glitch_cnt
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync;
  deb_state_t       state, state_next;
  logic [1:0]       cand, cand_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       in_next;
  logic             change_next;
  logic [7:0]       glitch_next;

  sync_chain #(
    .WIDTH (2),
    .DEPTH (NSYNC)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (raw_in),
    .q     (sync)
  );

  // Register the debounce state, candidate, counter and all outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= STABLE;
      cand       <= 2'b00;
      cnt        <= '0;
      in_        <= 2'b00;
      change     <= 1'b0;
      glitch_cnt <= 8'd0;
    end else begin
      state      <= state_next;
      cand       <= cand_next;
      cnt        <= cnt_next;
      in_        <= in_next;
      change     <= change_next;
      glitch_cnt <= glitch_next;
    end
  end

  // Whole-symbol debounce: any deviation from the candidate restarts or abandons it.
  always_comb begin
    state_next  = state;
    cand_next   = cand;
    cnt_next    = cnt;
    in_next     = in_;
    change_next = 1'b0;
    glitch_next = glitch_cnt;
    case (state)
      STABLE: begin
        if (sync != in_) begin
          cand_next  = sync;
          cnt_next   = CNT_ONE;
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (sync == cand) begin
          if (cnt == CNT_LAST) begin
            in_next     = cand;
            change_next = 1'b1;
            cnt_next    = '0;
            state_next  = STABLE;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end else if (sync == in_) begin
          glitch_next = sat_inc(glitch_cnt);
          cnt_next    = '0;
          state_next  = STABLE;
        end else begin
          glitch_next = sat_inc(glitch_cnt);
          cand_next   = sync;
          cnt_next    = CNT_ONE;
        end
      end
      default: begin
        state_next = STABLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fsm_input_debouncer.sv
// tb/tb_fsm_input_debouncer.sv - self-checking bench for fsm_input_debouncer
module tb_fsm_input_debouncer;

  localparam int NSYNC = 2;
  localparam int DEB   = 4;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic [1:0] raw_in = 2'b00;
  logic [1:0] in_;
  logic       change;
  logic [7:0] glitch_cnt;

  always #5 clk = ~clk;

  fsm_input_debouncer #(
    .NSYNC           (NSYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_in     (raw_in),
    .in_        (in_),
    .change     (change),
    .glitch_cnt (glitch_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: run-length view of the synchronized symbol stream.
  logic [1:0] dq [NSYNC];
  logic [1:0] prev_s;
  logic [1:0] m_in;
  logic       m_change;
  int         m_glitch;
  int         run;

  task automatic model_reset();
    for (int i = 0; i < NSYNC; i++) dq[i] = 2'b00;
    prev_s   = 2'b00;
    m_in     = 2'b00;
    m_change = 1'b0;
    m_glitch = 0;
    run      = 1;
  endtask

  task automatic model_step(input logic [1:0] raw);
    logic [1:0] s;
    s = dq[NSYNC-1];
    m_change = 1'b0;
    if (s != prev_s) begin
      if (prev_s != m_in && m_glitch < 255) m_glitch++;
      run = 1;
    end else if (run < 1000) begin
      run++;
    end
    if (run == DEB && s != m_in) begin
      m_in     = s;
      m_change = 1'b1;
    end
    prev_s = s;
    for (int i = NSYNC - 1; i > 0; i--) dq[i] = dq[i-1];
    dq[0] = raw;
  endtask

  task automatic tick(input logic [1:0] v);
    raw_in = v;
    @(posedge clk);
    if (reset) model_reset();
    else model_step(v);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    tick(2'b00);
    tick(2'b00);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0] raw;
    logic [1:0] exp_in;
    logic       exp_change;
    logic [7:0] exp_glitch;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] r, input logic [1:0] i, input logic c, input logic [7:0] g);
    vec_t v;
    v.raw = r; v.exp_in = i; v.exp_change = c; v.exp_glitch = g;
    vecs.push_back(v);
  endtask

  initial begin
    int  ch_seen;
    int  len;
    logic [1:0] val;

    // Clean 00->01, then 01->00, staggered 00->01->11, then a short 01 glitch over 11.
    for (int i = 1; i <= 8; i++)  add(2'b01, (i >= 6) ? 2'b01 : 2'b00, i == 6, 8'd0);
    for (int i = 1; i <= 8; i++)  add(2'b00, (i >= 6) ? 2'b00 : 2'b01, i == 6, 8'd0);
    for (int i = 1; i <= 10; i++) add((i <= 2) ? 2'b01 : 2'b11, (i >= 8) ? 2'b11 : 2'b00, i == 8, (i >= 5) ? 8'd1 : 8'd0);
    for (int i = 1; i <= 8; i++)  add((i <= 2) ? 2'b01 : 2'b11, 2'b11, 1'b0, (i >= 5) ? 8'd2 : 8'd1);

    // Reset values, held with raw_in = 11.
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick(2'b11);
      check("reset_in", in_, 0);
      check("reset_change", change, 0);
      check("reset_glitch", glitch_cnt, 0);
    end
    reset = 1'b0;

    // Table-driven vectors.
    foreach (vecs[k]) begin
      tick(vecs[k].raw);
      check($sformatf("vec%0d_in", k), in_, vecs[k].exp_in);
      check($sformatf("vec%0d_change", k), change, vecs[k].exp_change);
      check($sformatf("vec%0d_glitch", k), glitch_cnt, vecs[k].exp_glitch);
    end

    // Short glitch: 10 for two cycles from a clean 00.
    do_reset();
    ch_seen = 0;
    for (int i = 1; i <= 8; i++) begin
      tick((i <= 2) ? 2'b10 : 2'b00);
      if (change) ch_seen++;
      check("glitch_in", in_, 0);
    end
    check("glitch_change_seen", ch_seen, 0);
    check("glitch_count", glitch_cnt, 1);

    // Saturation with 1-cycle pulses.
    do_reset();
    ch_seen = 0;
    for (int p = 0; p < 100; p++) begin
      tick(2'b01); if (change) ch_seen++;
      tick(2'b00); if (change) ch_seen++;
      tick(2'b00); if (change) ch_seen++;
    end
    check("sat_mid_count", glitch_cnt, 99);
    for (int p = 0; p < 200; p++) begin
      tick(2'b01); if (change) ch_seen++;
      tick(2'b00); if (change) ch_seen++;
      tick(2'b00); if (change) ch_seen++;
    end
    check("sat_count", glitch_cnt, 255);
    for (int p = 0; p < 20; p++) begin
      tick(2'b01);
      tick(2'b00);
      tick(2'b00);
      check("sat_hold", glitch_cnt, 255);
    end
    check("sat_change_seen", ch_seen, 0);
    check("sat_in", in_, 0);

    // Reset pulsed mid-debounce.
    do_reset();
    for (int i = 0; i < 4; i++) tick(2'b11);
    reset = 1'b1;
    model_reset();
    #1;
    check("mid_rst_in", in_, 0);
    check("mid_rst_change", change, 0);
    check("mid_rst_glitch", glitch_cnt, 0);
    tick(2'b11);
    check("mid_rst_hold_in", in_, 0);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick(2'b11);
      check($sformatf("mid_rst_e%0d_in", i), in_, (i >= NSYNC + DEB) ? 3 : 0);
      check($sformatf("mid_rst_e%0d_change", i), change, (i == NSYNC + DEB) ? 1 : 0);
      check($sformatf("mid_rst_e%0d_glitch", i), glitch_cnt, 0);
    end

    // Random runs checked against the reference model.
    do_reset();
    for (int r = 0; r < 200; r++) begin
      val = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 7);
      for (int c = 0; c < len; c++) begin
        tick(val);
        check("rand_in", in_, m_in);
        check("rand_change", change, m_change);
        check("rand_glitch", glitch_cnt, m_glitch);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
